multi_tick_gen: RTL and testbench

MULTI_TICK_GEN -- requirements
Module: multi_tick_gen

---
 rtl/tick_gen_pkg.sv | 15 +
 rtl/tick_div_ch.sv | 59 +++++
 rtl/multi_tick_gen.sv | 57 +++++
 tb/tb_multi_tick_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared rate arithmetic and limits for multi_tick_gen.
package tick_gen_pkg;

   localparam int MAX_CH = 16;

   function automatic int calc_prescale(input int clk_hz, input int base_hz);
      return clk_hz / base_hz;
   endfunction

   // One spare bit so PRESCALE-1 always fits, even at exact powers of two.
   function automatic int width_of(input int v);
      return $clog2(v) + 1;
   endfunction

endpackage

// File: rtl/tick_div_ch.sv
// tick_div_ch: one divider channel counting base ticks, emitting a one-cycle tick.
// Square-wave toggle flop present only when MULTI_TICK_GEN_SQUARE_EN is defined.
module tick_div_ch
   import tick_gen_pkg::*;
#(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic                 sync,
   input  logic                 base_tick,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 tick_out
`ifdef MULTI_TICK_GEN_SQUARE_EN
   ,
   output logic                 clk_out
`endif
);

   logic [DIV_WIDTH-1:0] r_cnt;
   logic                 r_tick;
   logic                 w_zero;
   logic                 w_wrap;
   logic                 w_fire;

   // ">=" rather than "==" so a ratio lowered below the current count wraps at once.
   assign w_zero = (div == '0);
   assign w_wrap = !w_zero && (r_cnt >= div - 1'b1);
   assign w_fire = base_tick && w_wrap;

   always_ff @(posedge clk_in) begin
      if (reset || sync) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_fire;
         if (w_zero)
            r_cnt <= '0;
         else if (base_tick)
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end
   end

   assign tick_out = r_tick;

`ifdef MULTI_TICK_GEN_SQUARE_EN
   logic r_sq;

   always_ff @(posedge clk_in) begin
      if (reset || sync)
         r_sq <= 1'b0;
      else if (w_fire)
         r_sq <= ~r_sq;
   end

   assign clk_out = r_sq;
`endif

endmodule

// File: rtl/multi_tick_gen.sv
// multi_tick_gen: shared prescaler feeding NUM_CH independent tick dividers.
// Define MULTI_TICK_GEN_SQUARE_EN to add the per-channel clk_out square waves.
module multi_tick_gen
   import tick_gen_pkg::*;
#(
   parameter int CLK_IN_RATE_HZ = 1_000_000,
   parameter int BASE_RATE_HZ   = 10,
   parameter int NUM_CH         = 2,
   parameter int DIV_WIDTH      = 8
) (
   input  logic                        clk_in,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        sync,
   input  logic [NUM_CH*DIV_WIDTH-1:0] div,
   output logic [NUM_CH-1:0]           tick_out
`ifdef MULTI_TICK_GEN_SQUARE_EN
   ,
   output logic [NUM_CH-1:0]           clk_out
`endif
);

   localparam int PRESCALE = calc_prescale(CLK_IN_RATE_HZ, BASE_RATE_HZ);
   localparam int PW       = width_of(PRESCALE);
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] r_pre;
   logic          w_base;

   assign w_base = enable && (r_pre == PRE_LAST);

   always_ff @(posedge clk_in) begin
      if (reset || sync)
         r_pre <= '0;
      else if (enable)
         r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
   end

   // Channels never see enable directly: a frozen prescaler yields no base ticks.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      tick_div_ch #(
         .DIV_WIDTH(DIV_WIDTH)
      ) u_ch (
         .clk_in   (clk_in),
         .reset    (reset),
         .sync     (sync),
         .base_tick(w_base),
         .div      (div[i*DIV_WIDTH +: DIV_WIDTH]),
         .tick_out (tick_out[i])
`ifdef MULTI_TICK_GEN_SQUARE_EN
         ,
         .clk_out  (clk_out[i])
`endif
      );
   end

endmodule

// File: tb/tb_multi_tick_gen.sv
// tb_multi_tick_gen: directed scoreboard bench; expected tick cycles queued per channel.
module tb_multi_tick_gen;

   logic       clk_in = 1'b0;
   logic       reset  = 1'b1;
   logic       enable = 1'b0;
   logic       sync   = 1'b0;
   logic [7:0] div    = '0;
   logic [1:0] tick_out;
`ifdef MULTI_TICK_GEN_SQUARE_EN
   logic [1:0] clk_out;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int q0[$];
   int q1[$];

   multi_tick_gen #(
      .CLK_IN_RATE_HZ(100),
      .BASE_RATE_HZ  (10),
      .NUM_CH        (2),
      .DIV_WIDTH     (4)
   ) dut (
      .clk_in  (clk_in),
      .reset   (reset),
      .enable  (enable),
      .sync    (sync),
      .div     (div),
      .tick_out(tick_out)
`ifdef MULTI_TICK_GEN_SQUARE_EN
      ,
      .clk_out (clk_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Every observed pulse must match the oldest queued expected cycle.
   always @(negedge clk_in) begin
      if (tick_out[0] === 1'b1)
         chk("tick0_cycle", cyc, (q0.size() > 0) ? q0.pop_front() : -1);
      if (tick_out[1] === 1'b1)
         chk("tick1_cycle", cyc, (q1.size() > 0) ? q1.pop_front() : -1);
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk_in);
   endtask

   task automatic do_reset(input logic [3:0] d0, input logic [3:0] d1, output int r);
      @(negedge clk_in);
      reset  = 1'b1;
      sync   = 1'b0;
      enable = 1'b1;
      div    = {d1, d0};
      @(negedge clk_in);
      reset = 1'b0;
      r     = cyc;
      chk("reset_tick", tick_out, 0);
`ifdef MULTI_TICK_GEN_SQUARE_EN
      chk("reset_sq", clk_out, 0);
`endif
   endtask

   task automatic chk_drained(input string tag);
      chk({tag, "_q0"}, q0.size(), 0);
      chk({tag, "_q1"}, q1.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      int r2;
      logic sq_bad;
      // base rate 1/10 cycles: ch0 div=1, ch1 div=5
      do_reset(4'd1, 4'd5, r);
      for (int k = 1; k <= 10; k++) q0.push_back(r + 10 * k);
      q1.push_back(r + 50);
      q1.push_back(r + 100);
`ifdef MULTI_TICK_GEN_SQUARE_EN
      wait_until(r + 10);
      chk("sq0_first_toggle", clk_out[0], 1);
      wait_until(r + 20);
      chk("sq0_second_toggle", clk_out[0], 0);
      wait_until(r + 49);
      chk("sq1_before", clk_out[1], 0);
      wait_until(r + 50);
      chk("sq1_rise", clk_out[1], 1);
      wait_until(r + 99);
      chk("sq1_high", clk_out[1], 1);
      wait_until(r + 100);
      chk("sq1_fall", clk_out[1], 0);
`endif
      wait_until(r + 50);
      chk("coincident_50", tick_out, 2'b11);
      wait_until(r + 100);
      chk("coincident_100", tick_out, 2'b11);
      wait_until(r + 105);
      chk_drained("basic");

      // ch0 div=0 stays silent
      do_reset(4'd0, 4'd5, r);
      for (int k = 1; k <= 4; k++) q1.push_back(r + 50 * k);
      sq_bad = 1'b0;
      while (cyc < r + 200) begin
         @(negedge clk_in);
`ifdef MULTI_TICK_GEN_SQUARE_EN
         if (clk_out[0] !== 1'b0) sq_bad = 1'b1;
`endif
      end
      chk("div0_sq_const", sq_bad, 0);
      wait_until(r + 205);
      chk_drained("div0");

      // ratio lowered from 8 to 3 while count is 6
      do_reset(4'd8, 4'd5, r);
      q0.push_back(r + 70);
      q0.push_back(r + 100);
      q0.push_back(r + 130);
      q0.push_back(r + 160);
      q1.push_back(r + 50);
      q1.push_back(r + 100);
      q1.push_back(r + 150);
      wait_until(r + 62);
      div[3:0] = 4'd3;
      wait_until(r + 165);
      chk_drained("div_change");

      // freeze 37 cycles with prescaler at 4
      do_reset(4'd1, 4'd5, r);
      q0.push_back(r + 10);
      for (int k = 0; k <= 4; k++) q0.push_back(r + 57 + 10 * k);
      q1.push_back(r + 87);
      wait_until(r + 14);
      enable = 1'b0;
      wait_until(r + 20);
      chk("frozen_no_tick", tick_out, 0);
      wait_until(r + 51);
      enable = 1'b1;
      wait_until(r + 100);
      chk_drained("enable");

      // sync landing on a base tick
      do_reset(4'd1, 4'd5, r);
      q0.push_back(r + 10);
      for (int k = 0; k <= 4; k++) q0.push_back(r + 30 + 10 * k);
      q1.push_back(r + 70);
      wait_until(r + 19);
      sync = 1'b1;
      @(negedge clk_in);
      sync = 1'b0;
      chk("sync_tick", tick_out, 0);
`ifdef MULTI_TICK_GEN_SQUARE_EN
      chk("sync_sq", clk_out, 0);
`endif
      wait_until(r + 75);
      chk_drained("sync");

      // reset with sync mid-period discards partial counts
      do_reset(4'd1, 4'd5, r);
      q0.push_back(r + 10);
      q0.push_back(r + 20);
      q0.push_back(r + 30);
      q0.push_back(r + 44);
      q0.push_back(r + 54);
      q0.push_back(r + 64);
      q0.push_back(r + 74);
      q0.push_back(r + 84);
      q1.push_back(r + 84);
      wait_until(r + 33);
      reset = 1'b1;
      sync  = 1'b1;
      @(negedge clk_in);
      r2 = cyc;
      chk("midreset_at", r2, r + 34);
      chk("midreset_tick", tick_out, 0);
`ifdef MULTI_TICK_GEN_SQUARE_EN
      chk("midreset_sq", clk_out, 0);
`endif
      reset = 1'b0;
      sync  = 1'b0;
      wait_until(r2 + 55);
      chk_drained("midreset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
